// File: rtl/systolic_skew_feeder_if.sv
// Handshake/bus bundle between a vector producer, the skew feeder and the PE array left edge.
// The feeder side uses the slave modport; the producer/array side uses the master modport.
interface systolic_skew_feeder_if #(
  parameter int ROWS       = 8,
  parameter int DATA_WIDTH = 8
);
  logic [ROWS*DATA_WIDTH-1:0] in_data;
  logic                       in_valid;
  logic                       in_last;
  logic                       in_ready;
  logic                       out_stall;
  logic [ROWS*DATA_WIDTH-1:0] out_data;
  logic [ROWS-1:0]            out_valid;
  logic                       busy;
  logic                       done;

  modport slave (
    input  in_data, in_valid, in_last, out_stall,
    output in_ready, out_data, out_valid, busy, done
  );

  modport master (
    output in_data, in_valid, in_last, out_stall,
    input  in_ready, out_data, out_valid, busy, done
  );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Skews column vectors into a diagonal wavefront (row r delayed r cycles) for a systolic array.
// Optional macro SKEW_FEEDER_BYPASS_EN adds a per-tile `bypass` input that disables the skew.
module systolic_skew_feeder #(
  parameter int ROWS       = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef SKEW_FEEDER_BYPASS_EN
  input  logic                  bypass,
`endif
  systolic_skew_feeder_if.slave bus
);

  localparam int CW = $clog2(ROWS) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   flush_cnt_q, flush_cnt_d;
  logic            done_q, done_d;
  logic            advance;
  logic            accept;
  logic            last_direct;
  logic            lane_clr;

  assign advance      = !bus.out_stall;
  assign bus.in_ready = advance && (state_q != FLUSH);
  assign accept       = bus.in_valid && bus.in_ready;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;

`ifdef SKEW_FEEDER_BYPASS_EN
  logic mode_q, mode_d;
  logic skew_off;

  // The tile's mode is chosen on the opening accept; mid-tile decisions use the stored mode.
  assign skew_off    = (state_q == IDLE) ? bypass : mode_q;
  assign last_direct = (ROWS == 1) || skew_off;
  assign lane_clr    = mode_q;

  always_comb begin
    mode_d = mode_q;
    if (accept && state_q == IDLE) mode_d = bypass;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       mode_q <= 1'b0;
    else if (advance) mode_q <= mode_d;
  end
`else
  assign last_direct = (ROWS == 1);
  assign lane_clr    = 1'b0;
`endif

  // NOTE: every variable driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE, STREAM: begin
        if (accept) begin
          if (!bus.in_last) begin
            state_d = STREAM;
          end else if (last_direct) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d     = FLUSH;
            flush_cnt_d = CW'(ROWS - 1);
          end
        end
      end
      FLUSH: begin
        if (flush_cnt_q == CW'(1)) begin
          state_d     = IDLE;
          flush_cnt_d = '0;
          done_d      = 1'b1;
        end else begin
          flush_cnt_d = flush_cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      flush_cnt_q <= '0;
      done_q      <= 1'b0;
    end else if (advance) begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      done_q      <= done_d;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [DATA_WIDTH-1:0] data_q [0:r];
    logic [r:0]            valid_q;

    // NOTE: delay-line stages are reset because out_data/out_valid must read zero straight out of reset.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int k = 0; k <= r; k++) data_q[k] <= '0;
        valid_q <= '0;
      end else if (advance) begin
        data_q[0]  <= accept ? bus.in_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;
        valid_q[0] <= accept;
        for (int k = 1; k <= r; k++) begin
          data_q[k]  <= lane_clr ? '0 : data_q[k-1];
          valid_q[k] <= lane_clr ? 1'b0 : valid_q[k-1];
        end
      end
    end

`ifdef SKEW_FEEDER_BYPASS_EN
    assign bus.out_data[r*DATA_WIDTH +: DATA_WIDTH] = mode_q ? data_q[0] : data_q[r];
    assign bus.out_valid[r]                         = mode_q ? valid_q[0] : valid_q[r];
`else
    assign bus.out_data[r*DATA_WIDTH +: DATA_WIDTH] = data_q[r];
    assign bus.out_valid[r]                         = valid_q[r];
`endif
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed self-checking bench for systolic_skew_feeder with ROWS=4, DATA_WIDTH=8.
module tb_systolic_skew_feeder;

  logic clk;
  logic reset;
`ifdef SKEW_FEEDER_BYPASS_EN
  logic bypass;
`endif

  int total = 0;
  int bad   = 0;

  systolic_skew_feeder_if #(.ROWS(4), .DATA_WIDTH(8)) bus ();

  systolic_skew_feeder #(.ROWS(4), .DATA_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef SKEW_FEEDER_BYPASS_EN
    .bypass(bypass),
`endif
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] v, input logic [31:0] d);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
    chk({tag, ".data"}, bus.out_data, d);
  endtask

  // ctl = {in_ready, busy, done}
  task automatic expect_ctl(input string tag, input logic [2:0] ctl);
    chk({tag, ".ctl"}, 32'({bus.in_ready, bus.busy, bus.done}), 32'(ctl));
  endtask

  task automatic expect_cnt(input string tag, input logic [31:0] cnt);
    chk({tag, ".cnt"}, 32'(dut.flush_cnt_q), cnt);
  endtask

  // One-vector tile from IDLE: row r appears alone in cycle t+1+r, done with row 3.
  task automatic tile_single(input string tag, input logic [31:0] vec);
    bus.in_data  = vec;
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b1;
    expect_ctl({tag, ".pre"}, 3'b100);
    step();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
    for (int r = 0; r < 4; r++) begin
      expect_out($sformatf("%s.c%0d", tag, r + 1), 4'(1 << r), vec & (32'hFF << (8 * r)));
      expect_ctl($sformatf("%s.c%0d", tag, r + 1), (r == 3) ? 3'b101 : 3'b010);
      step();
    end
    expect_out({tag, ".after"}, 4'b0000, 32'h0);
    expect_ctl({tag, ".after"}, 3'b100);
  endtask

  initial begin
    reset         = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_stall = 1'b0;
`ifdef SKEW_FEEDER_BYPASS_EN
    bypass = 1'b0;
`endif

    // Reset state
    #2;
    expect_out("rst", 4'b0000, 32'h0);
    expect_ctl("rst", 3'b100);
    expect_cnt("rst", 0);
    bus.out_stall = 1'b1;
    #1;
    expect_ctl("rst.stall", 3'b000);
    bus.out_stall = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step();

    // Single vector with last
    tile_single("single", 32'h04030201);

    // Back-to-back A, B, C(last)
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b0;
    bus.in_data  = 32'hA3A2A1A0;
    step();
    expect_out("b2b.c1", 4'b0001, 32'h000000A0);
    expect_ctl("b2b.c1", 3'b110);
    bus.in_data = 32'hB3B2B1B0;
    step();
    expect_out("b2b.c2", 4'b0011, 32'h0000A1B0);
    expect_ctl("b2b.c2", 3'b110);
    bus.in_data = 32'hC3C2C1C0;
    bus.in_last = 1'b1;
    step();
    expect_out("b2b.c3", 4'b0111, 32'h00A2B1C0);
    expect_ctl("b2b.c3", 3'b010);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
    step();
    expect_out("b2b.c4", 4'b1110, 32'hA3B2C100);
    expect_ctl("b2b.c4", 3'b010);
    step();
    expect_out("b2b.c5", 4'b1100, 32'hB3C20000);
    expect_ctl("b2b.c5", 3'b010);
    step();
    expect_out("b2b.c6", 4'b1000, 32'hC3000000);
    expect_ctl("b2b.c6", 3'b101);
    step();
    expect_out("b2b.c7", 4'b0000, 32'h0);
    expect_ctl("b2b.c7", 3'b100);

    // Gap stream: A, two idle cycles, B(last)
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h13121110;
    step();
    expect_out("gap.c1", 4'b0001, 32'h00000010);
    expect_ctl("gap.c1", 3'b110);
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    step();
    expect_out("gap.c2", 4'b0010, 32'h00001100);
    expect_ctl("gap.c2", 3'b110);
    step();
    expect_out("gap.c3", 4'b0100, 32'h00120000);
    expect_ctl("gap.c3", 3'b110);
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b1;
    bus.in_data  = 32'h23222120;
    step();
    expect_out("gap.c4", 4'b1001, 32'h13000020);
    expect_ctl("gap.c4", 3'b010);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
    step();
    expect_out("gap.c5", 4'b0010, 32'h00002100);
    step();
    expect_out("gap.c6", 4'b0100, 32'h00220000);
    step();
    expect_out("gap.c7", 4'b1000, 32'h23000000);
    expect_ctl("gap.c7", 3'b101);
    step();
    expect_out("gap.c8", 4'b0000, 32'h0);

    // Stall for 3 cycles mid-FLUSH; producer holds a vector that must not be taken
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b1;
    bus.in_data  = 32'h34333231;
    step();
    expect_out("stl.c1", 4'b0001, 32'h00000031);
    expect_cnt("stl.c1", 3);
    bus.in_data = 32'hEEEEEEEE;
    step();
    expect_out("stl.c2", 4'b0010, 32'h00003200);
    expect_cnt("stl.c2", 2);
    bus.out_stall = 1'b1;
    #1;
    expect_ctl("stl.c2", 3'b010);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out($sformatf("stl.hold%0d", i), 4'b0010, 32'h00003200);
      expect_cnt($sformatf("stl.hold%0d", i), 2);
      expect_ctl($sformatf("stl.hold%0d", i), 3'b010);
    end
    bus.out_stall = 1'b0;
    step();
    expect_out("stl.c6", 4'b0100, 32'h00330000);
    expect_cnt("stl.c6", 1);
    expect_ctl("stl.c6", 3'b010);
    step();
    expect_out("stl.c7", 4'b1000, 32'h34000000);
    expect_ctl("stl.c7", 3'b101);
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_data   = '0;
    bus.out_stall = 1'b1;
    step();
    expect_out("stl.dhold", 4'b1000, 32'h34000000);
    expect_ctl("stl.dhold", 3'b001);
    bus.out_stall = 1'b0;
    step();
    expect_out("stl.end", 4'b0000, 32'h0);
    expect_ctl("stl.end", 3'b100);

    // Reset pulse while row 2 of A is still in flight
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h63626160;
    step();
    expect_out("arst.c1", 4'b0001, 32'h00000060);
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    step();
    expect_out("arst.c2", 4'b0010, 32'h00006100);
    expect_ctl("arst.c2", 3'b110);
    #2;
    reset = 1'b0;
    #1;
    expect_out("arst.low", 4'b0000, 32'h0);
    expect_ctl("arst.low", 3'b100);
    @(negedge clk);
    reset = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      expect_out($sformatf("arst.gone%0d", i), 4'b0000, 32'h0);
      step();
    end
    tile_single("arst.D", 32'h74737271);

`ifdef SKEW_FEEDER_BYPASS_EN
    // Bypass tile: no skew, done right away; skew resumes for the next tile
    bypass       = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b1;
    bus.in_data  = 32'h04030201;
    step();
    expect_out("byp.c1", 4'b1111, 32'h04030201);
    expect_ctl("byp.c1", 3'b101);
    bypass       = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
    step();
    expect_out("byp.c2", 4'b0000, 32'h0);
    expect_ctl("byp.c2", 3'b100);
    step();
    tile_single("byp.after", 32'h84838281);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

- Upstream stage of the systolic PE array. Drives the array's per-row left-edge inputs (`data_in_left`).
- Accepts one full column vector per handshake, ROWS elements wide.
- Delays row r by r extra cycles, producing the diagonal wavefront the array needs.
- Injects zero bubbles when no data is available, and flushes the wavefront after the last vector of a tile.

## Interface
Parameters:
- ROWS, 8, number of array rows fed (≥1).
- DATA_WIDTH, 8, element width; matches PE data width.

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low; clears all state when 0.
- in_data  input  ROWS*DATA_WIDTH  column vector; row r at bits [r*DATA_WIDTH +: DATA_WIDTH].
- in_valid  input  1  in_data valid.
- in_last  input  1  marks the final vector of a tile; qualified by in_valid.
- in_ready  output  1  feeder can accept a vector this cycle.
- out_stall  input  1  downstream freeze; holds all feeder state.
- out_data  output  ROWS*DATA_WIDTH  skewed row outputs to the array's left edge.
- out_valid  output  ROWS  per-row valid; bit r qualifies out_data row r.
- busy  output  1  state ≠ IDLE.
- done  output  1  one-cycle pulse when the last row of the last vector is presented.

## Operation
- Accept: `in_valid && in_ready` at a rising edge.
- Row r has a delay line of depth r+1 for both data and valid.
  - Stage 0 loads in_data row r on accept.
  - Otherwise stage 0 loads zero with valid 0 (bubble).
  - out_data and out_valid are driven from the final stage of each line.
- `in_ready = !out_stall && state != FLUSH`.
  - Combinational; not registered.
- When out_stall=1, every register holds its value: delay lines, state, counter, done.
  - out_data and out_valid are held stable.
- FSM states: IDLE, STREAM, FLUSH.
  - IDLE → STREAM: accept with in_last=0.
  - IDLE or STREAM → FLUSH: accept with in_last=1, when ROWS>1. flush_cnt loads ROWS-1.
  - IDLE or STREAM → IDLE: accept with in_last=1, when ROWS=1. done is set.
  - STREAM holds while in_valid=0; bubbles are injected.
  - FLUSH: flush_cnt decrements each non-stalled cycle.
  - FLUSH → IDLE: in the non-stalled cycle where flush_cnt==1. done is registered high for the following cycle.
- done is high for exactly one cycle, then clears.
  - Exception: if out_stall=1 in that cycle, done holds until the next non-stalled edge.
- Arithmetic and widths:
  - Data passes through unmodified.
  - flush_cnt width is $clog2(ROWS)+1.
  - No wrap: flush_cnt never decrements below 1 while in FLUSH.

## Timing
- Reset values: out_data=0, out_valid=0, busy=0, done=0, state=IDLE, flush_cnt=0.
  - in_ready=1 whenever out_stall=0.
- Latency: vector accepted at edge t → row r visible on out_data/out_valid in cycle t+1+r.
  - These are non-stalled cycles; each stalled cycle adds one.
- Last vector accepted at edge t (no stalls):
  - FLUSH occupies cycles t+1 … t+ROWS-1.
  - in_ready=0 throughout FLUSH.
  - done=1 and state=IDLE in cycle t+ROWS, coincident with out_valid[ROWS-1] for that vector.
  - in_ready=1 again in cycle t+ROWS.
- Back-to-back accepts give full throughput: one vector per cycle, no bubbles.
- An in_valid=1 while in_ready=0 is not accepted; the producer must hold the data.
- Reset asserted mid-operation: all outputs go to reset values immediately (asynchronous). Any partial wavefront is discarded.

## Configuration
- Macro: `SKEW_FEEDER_BYPASS_EN`.
- Defined:
  - Adds input port `bypass` (1 bit), sampled only in IDLE on accept.
  - When bypass=1 for a tile, every row uses a depth-1 delay (no skew).
  - in_last goes directly to IDLE, with done in cycle t+1.
  - A mode register holds the choice until the tile ends.
- Undefined: no `bypass` port; skew is always applied.

## Test plan
Bench configuration for all scenarios: ROWS=4, DATA_WIDTH=8.

- Single vector {0x04,0x03,0x02,0x01} (row3..row0) with in_last, accepted at edge t:
  - Row0=0x01 at t+1, row1=0x02 at t+2, row2=0x03 at t+3, row3=0x04 at t+4.
  - done=1 at t+4; in_ready=0 during t+1..t+3.
- Three back-to-back vectors A, B, C (C with last):
  - out_valid[2] high for cycles t+3, t+4, t+5 carrying A2, B2, C2.
  - No bubbles; done at t+6.
- Gap stream: A, then in_valid=0 for 2 cycles, then B(last):
  - Two zero/valid-0 cycles between A and B on every row, each row offset by its skew.
- out_stall=1 for 3 cycles mid-FLUSH:
  - out_data and out_valid frozen; flush_cnt unchanged.
  - done delayed by exactly 3 cycles.
  - in_ready=0 throughout.
- reset=0 pulse while row2 of A is pending:
  - All out_valid=0, busy=0 immediately.
  - After release, A never appears; a new vector D is accepted normally.
- With `SKEW_FEEDER_BYPASS_EN` and bypass=1, vector {4,3,2,1} with last:
  - All four rows valid at t+1; done at t+1.
